// File: rtl/reset_sequencer.sv
// reset_sequencer: holds reset channels until lock and POR delay are clean, releases them in order, re-enters on faults
module reset_sequencer #(
    parameter int NUM_OUT    = 3,
    parameter int POR_CYCLES = 256,
    parameter int STAGE_GAP  = 16,
    parameter int LOCK_FILT  = 64,
    parameter int CNT_W      = 16
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               pll_lock,
    input  logic               ext_rst_n,
    input  logic               soft_rst,
    output logic [NUM_OUT-1:0] rst_out,
    output logic               done,
    output logic [3:0]         cause,
    output logic [7:0]         rst_count
);
    typedef enum logic [1:0] {ASSERT, RELEASE, RUN} state_t;
    state_t               r_state = ASSERT, w_state_nxt;
    logic                 r_lock_m = 1'b0, r_lock_s = 1'b0, r_ext_m = 1'b0, r_ext_s = 1'b0;
    logic [CNT_W-1:0]     r_lock_cnt = '0, r_por_cnt = '0, r_stage_cnt = '0;
    logic [CNT_W-1:0]     w_por_nxt, w_stage_nxt;
    logic [3:0]           r_idx = '0, w_idx_nxt;
    logic [NUM_OUT-1:0]   r_rst_out = '1, w_rst_nxt;
    logic                 r_done = 1'b0, w_done_nxt;
    logic [3:0]           r_cause = 4'b0001, w_cause_nxt;
    logic [7:0]           r_rst_count = '0, w_count_nxt;
    logic                 w_lock_ok, w_trig;
    assign w_lock_ok = r_lock_cnt == CNT_W'(LOCK_FILT);
    assign w_trig    = !w_lock_ok | !r_ext_s | soft_rst;
    assign rst_out   = r_rst_out;
    assign done      = r_done;
    assign cause     = r_cause;
    assign rst_count = r_rst_count;
    // synchronisers deliberately keep running through master reset
    always_ff @(posedge clk) begin
        r_lock_m <= pll_lock;
        r_lock_s <= r_lock_m;
        r_ext_m  <= ext_rst_n;
        r_ext_s  <= r_ext_m;
    end
    always_comb begin
        w_state_nxt = r_state;
        w_por_nxt   = r_por_cnt;
        w_stage_nxt = r_stage_cnt;
        w_idx_nxt   = r_idx;
        w_rst_nxt   = r_rst_out;
        w_done_nxt  = r_done;
        w_cause_nxt = r_cause;
        w_count_nxt = r_rst_count;
        case (r_state)
            ASSERT: begin
                w_rst_nxt  = '1;
                w_done_nxt = 1'b0;
                if (w_trig)
                    w_por_nxt = '0;
                else if (r_por_cnt == CNT_W'(POR_CYCLES - 1)) begin
                    w_rst_nxt   = '1 << 1;
                    w_state_nxt = (NUM_OUT == 1) ? RUN : RELEASE;
                    w_done_nxt  = NUM_OUT == 1;
                    w_stage_nxt = '0;
                    w_idx_nxt   = 4'd1;
                end else
                    w_por_nxt = r_por_cnt + 1'b1;
            end
            RELEASE: begin
                if (r_stage_cnt == CNT_W'(STAGE_GAP - 1)) begin
                    w_rst_nxt   = r_rst_out & ~(NUM_OUT'(1) << r_idx);
                    w_idx_nxt   = r_idx + 4'd1;
                    w_stage_nxt = '0;
                    w_state_nxt = (r_idx == 4'(NUM_OUT - 1)) ? RUN : RELEASE;
                    w_done_nxt  = r_idx == 4'(NUM_OUT - 1);
                end else
                    w_stage_nxt = r_stage_cnt + 1'b1;
            end
            RUN: ;
            default: w_state_nxt = ASSERT;
        endcase
        // a fault outside ASSERT wins over any release due on the same edge
        if (r_state != ASSERT && w_trig) begin
            w_state_nxt = ASSERT;
            w_rst_nxt   = '1;
            w_done_nxt  = 1'b0;
            w_por_nxt   = '0;
            w_cause_nxt = {soft_rst, !r_ext_s, !w_lock_ok, 1'b0};
            w_count_nxt = (r_rst_count == 8'hFF) ? r_rst_count : r_rst_count + 8'd1;
        end
    end
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state     <= ASSERT;
            r_lock_cnt  <= '0;
            r_por_cnt   <= '0;
            r_stage_cnt <= '0;
            r_idx       <= '0;
            r_rst_out   <= '1;
            r_done      <= 1'b0;
            r_cause     <= 4'b0001;
            r_rst_count <= '0;
        end else begin
            r_state     <= w_state_nxt;
            r_lock_cnt  <= !r_lock_s ? '0 : w_lock_ok ? r_lock_cnt : r_lock_cnt + 1'b1;
            r_por_cnt   <= w_por_nxt;
            r_stage_cnt <= w_stage_nxt;
            r_idx       <= w_idx_nxt;
            r_rst_out   <= w_rst_nxt;
            r_done      <= w_done_nxt;
            r_cause     <= w_cause_nxt;
            r_rst_count <= w_count_nxt;
        end
    end
endmodule

// File: tb/tb_reset_sequencer.sv
// tb_reset_sequencer: directed scenarios with hand-computed edge timings for NUM_OUT=3, POR=8, GAP=2, FILT=4
module tb_reset_sequencer;
    logic       clk = 1'b0, reset = 1'b0, pll_lock = 1'b1, ext_rst_n = 1'b1, soft_rst = 1'b0;
    logic [2:0] rst_out;
    logic       done;
    logic [3:0] cause;
    logic [7:0] rst_count;
    int         checks = 0, failures = 0, edge_n = 0;

    always #5 clk = ~clk;

    reset_sequencer #(
        .NUM_OUT(3), .POR_CYCLES(8), .STAGE_GAP(2), .LOCK_FILT(4), .CNT_W(16)
    ) dut (
        .clk(clk), .reset(reset), .pll_lock(pll_lock), .ext_rst_n(ext_rst_n),
        .soft_rst(soft_rst), .rst_out(rst_out), .done(done), .cause(cause),
        .rst_count(rst_count)
    );

    task automatic tick;
        @(posedge clk);
        #1;
        edge_n++;
    endtask

    task automatic pulse_reset;
        reset = 1'b1;
        tick();
        reset = 1'b0;
        edge_n = 0;
    endtask

    task automatic run_to(input int n);
        while (edge_n < n) tick();
    endtask

    task automatic test_reset;
        pll_lock = 1'b1;
        ext_rst_n = 1'b1;
        reset = 1'b1;
        repeat (4) tick();
        checks += 4;
        if (rst_out !== 3'b111) begin failures++; $display("FAIL reset_rst_out got=%b exp=111", rst_out); end
        if (done !== 1'b0) begin failures++; $display("FAIL reset_done got=%b exp=0", done); end
        if (cause !== 4'b0001) begin failures++; $display("FAIL reset_cause got=%b exp=0001", cause); end
        if (rst_count !== 8'd0) begin failures++; $display("FAIL reset_count got=%0d exp=0", rst_count); end
        reset = 1'b0;
        edge_n = 0;
    endtask

    task automatic test_power_up;
        logic [2:0] exp_r;
        for (int n = 1; n <= 16; n++) begin
            run_to(n);
            exp_r = (n < 12) ? 3'b111 : (n < 14) ? 3'b110 : (n < 16) ? 3'b100 : 3'b000;
            checks += 2;
            if (rst_out !== exp_r) begin failures++; $display("FAIL pwr_rst_out edge=%0d got=%b exp=%b", n, rst_out, exp_r); end
            if (done !== (n >= 16)) begin failures++; $display("FAIL pwr_done edge=%0d got=%b exp=%b", n, done, n >= 16); end
        end
        checks += 2;
        if (cause !== 4'b0001) begin failures++; $display("FAIL pwr_cause got=%b exp=0001", cause); end
        if (rst_count !== 8'd0) begin failures++; $display("FAIL pwr_count got=%0d exp=0", rst_count); end
    endtask

    task automatic test_lock_glitch;
        int e;
        run_to(20);
        e = edge_n;
        pll_lock = 1'b0;
        tick();
        pll_lock = 1'b1;
        tick();
        checks += 1;
        if (rst_out !== 3'b000) begin failures++; $display("FAIL glitch_still_run got=%b exp=000", rst_out); end
        run_to(e + 4);
        checks += 4;
        if (rst_out !== 3'b111) begin failures++; $display("FAIL glitch_rst_out got=%b exp=111", rst_out); end
        if (done !== 1'b0) begin failures++; $display("FAIL glitch_done got=%b exp=0", done); end
        if (cause !== 4'b0010) begin failures++; $display("FAIL glitch_cause got=%b exp=0010", cause); end
        if (rst_count !== 8'd1) begin failures++; $display("FAIL glitch_count got=%0d exp=1", rst_count); end
        run_to(e + 14);
        checks += 1;
        if (rst_out !== 3'b111) begin failures++; $display("FAIL glitch_hold got=%b exp=111", rst_out); end
        run_to(e + 15);
        checks += 1;
        if (rst_out !== 3'b110) begin failures++; $display("FAIL glitch_rel0 got=%b exp=110", rst_out); end
        run_to(e + 19);
        checks += 2;
        if (rst_out !== 3'b000) begin failures++; $display("FAIL glitch_rel_all got=%b exp=000", rst_out); end
        if (done !== 1'b1) begin failures++; $display("FAIL glitch_done_again got=%b exp=1", done); end
    endtask

    task automatic test_late_lock;
        pll_lock = 1'b0;
        reset = 1'b1;
        repeat (3) tick();
        reset = 1'b0;
        edge_n = 0;
        run_to(20);
        pll_lock = 1'b1;
        checks += 2;
        if (rst_out !== 3'b111) begin failures++; $display("FAIL late_hold20 got=%b exp=111", rst_out); end
        if (cause !== 4'b0001) begin failures++; $display("FAIL late_cause got=%b exp=0001", cause); end
        run_to(33);
        checks += 1;
        if (rst_out !== 3'b111) begin failures++; $display("FAIL late_hold33 got=%b exp=111", rst_out); end
        run_to(34);
        checks += 1;
        if (rst_out !== 3'b110) begin failures++; $display("FAIL late_rel0 got=%b exp=110", rst_out); end
        run_to(36);
        checks += 1;
        if (rst_out !== 3'b100) begin failures++; $display("FAIL late_rel1 got=%b exp=100", rst_out); end
        run_to(38);
        checks += 3;
        if (rst_out !== 3'b000) begin failures++; $display("FAIL late_rel2 got=%b exp=000", rst_out); end
        if (done !== 1'b1) begin failures++; $display("FAIL late_done got=%b exp=1", done); end
        if (rst_count !== 8'd0) begin failures++; $display("FAIL late_count got=%0d exp=0", rst_count); end
    endtask

    task automatic test_soft_release;
        pulse_reset();
        run_to(13);
        checks += 1;
        if (rst_out !== 3'b110) begin failures++; $display("FAIL soft_pre got=%b exp=110", rst_out); end
        soft_rst = 1'b1;
        tick();
        soft_rst = 1'b0;
        checks += 4;
        if (rst_out !== 3'b111) begin failures++; $display("FAIL soft_rst_out got=%b exp=111", rst_out); end
        if (done !== 1'b0) begin failures++; $display("FAIL soft_done got=%b exp=0", done); end
        if (cause !== 4'b1000) begin failures++; $display("FAIL soft_cause got=%b exp=1000", cause); end
        if (rst_count !== 8'd1) begin failures++; $display("FAIL soft_count got=%0d exp=1", rst_count); end
        run_to(16);
        checks += 1;
        if (rst_out !== 3'b111) begin failures++; $display("FAIL soft_no_release got=%b exp=111", rst_out); end
    endtask

    task automatic test_button_assert;
        int b;
        run_to(17);
        ext_rst_n = 1'b0;
        repeat (50) tick();
        checks += 1;
        if (rst_out !== 3'b111) begin failures++; $display("FAIL btn_held got=%b exp=111", rst_out); end
        ext_rst_n = 1'b1;
        b = edge_n;
        run_to(b + 9);
        checks += 1;
        if (rst_out !== 3'b111) begin failures++; $display("FAIL btn_hold_after got=%b exp=111", rst_out); end
        run_to(b + 10);
        checks += 3;
        if (rst_out !== 3'b110) begin failures++; $display("FAIL btn_rel0 got=%b exp=110", rst_out); end
        if (cause !== 4'b1000) begin failures++; $display("FAIL btn_cause got=%b exp=1000", cause); end
        if (rst_count !== 8'd1) begin failures++; $display("FAIL btn_count got=%0d exp=1", rst_count); end
    endtask

    task automatic test_saturation;
        for (int i = 0; i < 300; i++) begin
            soft_rst = 1'b1;
            tick();
            soft_rst = 1'b0;
            repeat (39) tick();
            if (i == 9) begin
                checks += 1;
                if (rst_count !== 8'd11) begin failures++; $display("FAIL sat_mid got=%0d exp=11", rst_count); end
            end
        end
        checks += 4;
        if (rst_count !== 8'd255) begin failures++; $display("FAIL sat_count got=%0d exp=255", rst_count); end
        if (cause !== 4'b1000) begin failures++; $display("FAIL sat_cause got=%b exp=1000", cause); end
        if (rst_out !== 3'b000) begin failures++; $display("FAIL sat_rst_out got=%b exp=000", rst_out); end
        if (done !== 1'b1) begin failures++; $display("FAIL sat_done got=%b exp=1", done); end
        pulse_reset();
        checks += 4;
        if (rst_count !== 8'd0) begin failures++; $display("FAIL mrst_count got=%0d exp=0", rst_count); end
        if (cause !== 4'b0001) begin failures++; $display("FAIL mrst_cause got=%b exp=0001", cause); end
        if (rst_out !== 3'b111) begin failures++; $display("FAIL mrst_rst_out got=%b exp=111", rst_out); end
        if (done !== 1'b0) begin failures++; $display("FAIL mrst_done got=%b exp=0", done); end
    endtask

    initial begin
        test_reset();
        test_power_up();
        test_lock_glitch();
        test_late_lock();
        test_soft_release();
        test_button_assert();
        test_saturation();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/reset_sequencer.md
Name: reset_sequencer

Overview:
- Parametrised power-on and run-time reset controller for up5k SoC tops.
- Holds a set of downstream reset channels asserted until the PLL lock is stable and a POR delay has expired.
- Releases the channels one at a time, in index order, with a fixed gap between each.
- Re-enters reset on PLL lock loss, external button, or CPU soft-reset request, and records the cause and a re-entry count.

Parameters:
- NUM_OUT, 3: number of reset channels; range 1..8.
- POR_CYCLES, 256: clean cycles required in ASSERT before release begins; must be >= 2.
- STAGE_GAP, 16: cycles between successive channel releases; must be >= 1.
- LOCK_FILT, 64: consecutive synchronised-high lock samples required for lock_ok.
- CNT_W, 16: width of internal counters; must hold max(POR_CYCLES, STAGE_GAP, LOCK_FILT).

Ports:
- clk  in  1  system clock (PLL output).
- reset  in  1  synchronous active-high master reset.
- pll_lock  in  1  PLL LOCK, asynchronous.
- ext_rst_n  in  1  external reset button, active low, asynchronous.
- soft_rst  in  1  single-cycle soft-reset request from CPU register, clk domain.
- rst_out  out  NUM_OUT  per-channel active-high resets; bit 0 is released first.
- done  out  1  high when all channels are released (state RUN).
- cause  out  4  one-hot-or-multi cause of last reset: bit0 master/POR, bit1 lock loss, bit2 ext, bit3 soft.
- rst_count  out  8  number of run-time re-entries into ASSERT, saturating at 255.

Behaviour:
- Power-up initial values equal reset values, so the block works without an asserted reset.
- Reset values: state=ASSERT, rst_out=all ones, done=0, cause=4'b0001, rst_count=0, por/stage/lock counters=0, stage index=0.
- Synchronisers: pll_lock and ext_rst_n each pass through a 2-FF synchroniser giving lock_s and ext_s. Synchroniser flops are not cleared by reset.
- Lock filter: lock_cnt clears when lock_s=0; otherwise increments, saturating at LOCK_FILT. lock_ok = (lock_cnt == LOCK_FILT). lock_cnt is cleared by reset.
- trig = !lock_ok | !ext_s | soft_rst, evaluated every cycle.
- ASSERT state:
  - rst_out = all ones, done = 0.
  - If trig: por_cnt <= 0.
  - Else if por_cnt == POR_CYCLES-1: go to RELEASE, clear rst_out[0], stage_cnt <= 0, idx <= 1.
  - Else: por_cnt++.
- RELEASE state:
  - stage_cnt increments each cycle.
  - When stage_cnt == STAGE_GAP-1: clear rst_out[idx], idx++, stage_cnt <= 0.
  - When the cleared channel is NUM_OUT-1, enter RUN and set done=1 on the same edge.
  - If NUM_OUT=1, ASSERT transitions directly to RUN with done=1.
- RUN state: outputs are held.
- Any trig while in RELEASE or RUN:
  - Next edge: state=ASSERT, rst_out=all ones, done=0, por_cnt=0.
  - cause <= {soft_rst, !ext_s, !lock_ok, 1'b0} as sampled that cycle.
  - rst_count++ (saturating).
  - This takes priority over any release event in the same cycle.
- Triggers arriving while already in ASSERT only restart por_cnt; cause and rst_count are unchanged.
- Master reset mid-operation overrides everything and returns to the reset values on the next edge.
- Timing reference: edge n = nth edge with reset sampled low, with pll_lock and ext_rst_n held high long before.
  - lock_ok becomes true after edge LOCK_FILT.
  - rst_out[0] falls at edge LOCK_FILT+POR_CYCLES.
  - rst_out[i] falls at edge LOCK_FILT+POR_CYCLES+i*STAGE_GAP.
- All outputs are registered; there are no combinational paths from inputs to outputs.

Test Plan:
(Bench parameters for all scenarios: NUM_OUT=3, POR_CYCLES=8, STAGE_GAP=2, LOCK_FILT=4.)
- Clean power-up: pll_lock=1, ext_rst_n=1, reset pulse -> rst_out goes 111→110 at edge 12, →100 at 14, →000 at 16; done=1 at 16; cause=0001; rst_count=0.
- Late lock: pll_lock held 0 until edge 20 after reset, then 1 -> rst_out stays 111 through edge 20+2+4+7, then the release sequence runs with the same gaps.
- Lock glitch in RUN: pll_lock low for 1 cycle -> two edges later rst_out=111, done=0, cause=0010, rst_count=1; re-release follows LOCK_FILT+POR_CYCLES edges after the lock returns.
- Soft reset mid-RELEASE: soft_rst pulse on the same cycle rst_out[1] would clear -> rst_out=111 next edge, cause=1000, rst_count=1; the pending release does not occur.
- Button held in ASSERT: ext_rst_n=0 for 50 cycles during the POR count -> no release until 2+8 edges after release of the button; cause and rst_count are unchanged.
- Counter saturation and master reset: 300 soft_rst pulses spaced 40 cycles apart -> rst_count=255. A subsequent reset pulse -> rst_count=0, cause=0001, rst_out=111.
